// File: rtl/mux2_rr_arbiter_if.sv
// Valid/ready bundle between two sources, the round-robin select stage and its consumer.
// master: the traffic side (sources + downstream); slave: the arbiter.
interface mux2_rr_arbiter_if #(
  parameter int unsigned W = 8
);
  logic         a_valid;
  logic [W-1:0] a_data;
  logic         a_last;
  logic         a_ready;
  logic         b_valid;
  logic [W-1:0] b_data;
  logic         b_last;
  logic         b_ready;
  logic         y_valid;
  logic [W-1:0] y_data;
  logic         y_last;
  logic         y_ready;
  logic         sel;

  modport master (
    output a_valid, a_data, a_last, b_valid, b_data, b_last, y_ready,
    input  a_ready, b_ready, y_valid, y_data, y_last, sel
  );

  modport slave (
    input  a_valid, a_data, a_last, b_valid, b_data, b_last, y_ready,
    output a_ready, b_ready, y_valid, y_data, y_last, sel
  );
endinterface

// File: rtl/mux2_rr_arbiter.sv
// Round-robin 2:1 select into a one-deep output register; sel reports the source (0=A, 1=B).
// Optional burst locking under `define MUX2_RR_ARBITER_LOCK_EN.
module mux2_rr_arbiter #(
  parameter int unsigned W = 8
) (
  input logic            clk,
  input logic            rst,
  mux2_rr_arbiter_if.slave bus
);

`ifdef MUX2_RR_ARBITER_LOCK_EN
  typedef enum logic [1:0] {ARB, LOCK_A, LOCK_B} state_t;
  state_t state;
  state_t state_nxt;
`endif

  logic         prio;
  logic         prio_nxt;
  logic         arb_a;
  logic         arb_b;
  logic         grant_a;
  logic         grant_b;
  logic         space;
  logic         a_ready_c;
  logic         b_ready_c;
  logic         xfer_a;
  logic         xfer_b;
  logic [W-1:0] win_data;
  logic         win_last;

`ifdef MUX2_RR_ARBITER_LOCK_EN
  always_ff @(posedge clk) begin
    if (rst) state <= ARB;
    else     state <= state_nxt;
  end
`endif

  // Grant, handshake and next-pointer/next-state decode
  always_comb begin
    arb_a    = bus.a_valid & (~bus.b_valid | ~prio);
    arb_b    = bus.b_valid & (~bus.a_valid | prio);
    grant_a  = arb_a;
    grant_b  = arb_b;
    prio_nxt = prio;
`ifdef MUX2_RR_ARBITER_LOCK_EN
    state_nxt = state;
    case (state)
      LOCK_A: begin
        grant_a = bus.a_valid;
        grant_b = 1'b0;
      end
      LOCK_B: begin
        grant_a = 1'b0;
        grant_b = bus.b_valid;
      end
      default: ;
    endcase
`endif
    space     = ~bus.y_valid | bus.y_ready;
    a_ready_c = grant_a & space & ~rst;
    b_ready_c = grant_b & space & ~rst;
    xfer_a    = bus.a_valid & a_ready_c;
    xfer_b    = bus.b_valid & b_ready_c;
    win_data  = xfer_b ? bus.b_data : bus.a_data;
    win_last  = xfer_b ? bus.b_last : bus.a_last;
`ifdef MUX2_RR_ARBITER_LOCK_EN
    // Pointer moves only when a burst completes, so bursts never interleave
    case (state)
      ARB: begin
        if (xfer_a && !bus.a_last)      state_nxt = LOCK_A;
        else if (xfer_b && !bus.b_last) state_nxt = LOCK_B;
      end
      LOCK_A: if (xfer_a && bus.a_last) state_nxt = ARB;
      LOCK_B: if (xfer_b && bus.b_last) state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
    if (xfer_a && bus.a_last)      prio_nxt = 1'b1;
    else if (xfer_b && bus.b_last) prio_nxt = 1'b0;
`else
    if (xfer_a)      prio_nxt = 1'b1;
    else if (xfer_b) prio_nxt = 1'b0;
`endif
  end

  assign bus.a_ready = a_ready_c;
  assign bus.b_ready = b_ready_c;

  // Output register: load replaces a draining word in place, so no bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.y_valid <= 1'b0;
      bus.y_data  <= '0;
      bus.y_last  <= 1'b0;
      bus.sel     <= 1'b0;
      prio        <= 1'b0;
    end else if (xfer_a || xfer_b) begin
      bus.y_valid <= 1'b1;
      bus.y_data  <= win_data;
      bus.y_last  <= win_last;
      bus.sel     <= xfer_b;
      prio        <= prio_nxt;
    end else if (bus.y_ready) begin
      bus.y_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter: reset, single source, round robin, backpressure,
// burst behaviour (build dependent) and mid-burst reset.
module tb_mux2_rr_arbiter;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  mux2_rr_arbiter_if #(.W(8)) bus ();

  mux2_rr_arbiter #(.W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp5_d [4];
    logic       exp5_s [4];
    int         ai;
    logic       acc;

    total = 0;
    bad   = 0;
`ifdef MUX2_RR_ARBITER_LOCK_EN
    exp5_s[0] = 1'b0; exp5_s[1] = 1'b0; exp5_s[2] = 1'b0; exp5_s[3] = 1'b1;
    exp5_d[0] = 8'hA1; exp5_d[1] = 8'hA2; exp5_d[2] = 8'hA3; exp5_d[3] = 8'hB0;
`else
    exp5_s[0] = 1'b0; exp5_s[1] = 1'b1; exp5_s[2] = 1'b0; exp5_s[3] = 1'b1;
    exp5_d[0] = 8'hA1; exp5_d[1] = 8'hB0; exp5_d[2] = 8'hA2; exp5_d[3] = 8'hB0;
`endif

    // Reset held with both sources valid
    rst = 1'b1;
    bus.a_valid = 1'b1; bus.a_data = 8'h11; bus.a_last = 1'b1;
    bus.b_valid = 1'b1; bus.b_data = 8'h22; bus.b_last = 1'b1;
    bus.y_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_y_valid", 32'(bus.y_valid), 32'd0);
      chk("rst_y_data",  32'(bus.y_data),  32'h0);
      chk("rst_y_last",  32'(bus.y_last),  32'd0);
      chk("rst_sel",     32'(bus.sel),     32'd0);
      chk("rst_a_ready", 32'(bus.a_ready), 32'd0);
      chk("rst_b_ready", 32'(bus.b_ready), 32'd0);
    end

    // Single source A
    rst = 1'b0;
    bus.a_data = 8'h5A; bus.b_valid = 1'b0;
    #1;
    chk("single_a_ready", 32'(bus.a_ready), 32'd1);
    chk("single_b_ready", 32'(bus.b_ready), 32'd0);
    step();
    chk("single_y_valid", 32'(bus.y_valid), 32'd1);
    chk("single_y_data",  32'(bus.y_data),  32'h5A);
    chk("single_sel",     32'(bus.sel),     32'd0);
    chk("single_y_last",  32'(bus.y_last),  32'd1);
    bus.a_valid = 1'b0;
    step();
    chk("drain_y_valid", 32'(bus.y_valid), 32'd0);
    chk("drain_y_data",  32'(bus.y_data),  32'h5A);

    // Round robin, both valid, no gaps
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.a_valid = 1'b1; bus.a_data = 8'hAA; bus.a_last = 1'b1;
    bus.b_valid = 1'b1; bus.b_data = 8'hBB; bus.b_last = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rr_y_valid", 32'(bus.y_valid), 32'd1);
      chk("rr_sel",     32'(bus.sel),     32'(i % 2));
      chk("rr_y_data",  32'(bus.y_data),  (i % 2 == 1) ? 32'hBB : 32'hAA);
    end
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    step();
    chk("rr_idle_y_valid", 32'(bus.y_valid), 32'd0);

    // Backpressure holds the word; release loads the next one on the same edge
    bus.a_valid = 1'b1; bus.a_data = 8'h33;
    step();
    chk("bp_load_y_data", 32'(bus.y_data), 32'h33);
    chk("bp_load_sel",    32'(bus.sel),    32'd0);
    bus.y_ready = 1'b0;
    bus.a_data = 8'h44;
    bus.b_valid = 1'b1; bus.b_data = 8'h55;
    #1;
    chk("bp_a_ready", 32'(bus.a_ready), 32'd0);
    chk("bp_b_ready", 32'(bus.b_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_y_valid", 32'(bus.y_valid), 32'd1);
      chk("bp_y_data",  32'(bus.y_data),  32'h33);
      chk("bp_sel",     32'(bus.sel),     32'd0);
      chk("bp_a_ready", 32'(bus.a_ready), 32'd0);
      chk("bp_b_ready", 32'(bus.b_ready), 32'd0);
    end
    bus.y_ready = 1'b1;
    #1;
    chk("rel_a_ready", 32'(bus.a_ready), 32'd0);
    chk("rel_b_ready", 32'(bus.b_ready), 32'd1);
    step();
    chk("rel_y_valid", 32'(bus.y_valid), 32'd1);
    chk("rel_y_data",  32'(bus.y_data),  32'h55);
    chk("rel_sel",     32'(bus.sel),     32'd1);
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    step();

    // Three-beat burst from A against a steady B
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.b_valid = 1'b1; bus.b_data = 8'hB0; bus.b_last = 1'b1;
    ai = 0;
    for (int k = 0; k < 4; k++) begin
      bus.a_valid = (ai < 3);
      bus.a_data  = 8'(8'hA1 + ai);
      bus.a_last  = (ai == 2);
      #1;
      acc = bus.a_ready & bus.a_valid;
      step();
      chk("burst_y_valid", 32'(bus.y_valid), 32'd1);
      chk("burst_sel",     32'(bus.sel),     32'(exp5_s[k]));
      chk("burst_y_data",  32'(bus.y_data),  32'(exp5_d[k]));
      if (acc) ai++;
    end
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    step();

    // B opens a burst, then reset lands mid-burst
    bus.b_valid = 1'b1; bus.b_data = 8'hC1; bus.b_last = 1'b0;
    step();
    chk("lockb_y_valid", 32'(bus.y_valid), 32'd1);
    chk("lockb_sel",     32'(bus.sel),     32'd1);
    bus.a_valid = 1'b1; bus.a_data = 8'hD1; bus.a_last = 1'b1;
    #1;
`ifdef MUX2_RR_ARBITER_LOCK_EN
    chk("lockb_a_ready", 32'(bus.a_ready), 32'd0);
    chk("lockb_b_ready", 32'(bus.b_ready), 32'd1);
`else
    chk("lockb_a_ready", 32'(bus.a_ready), 32'd1);
    chk("lockb_b_ready", 32'(bus.b_ready), 32'd0);
`endif
    rst = 1'b1;
    step();
    chk("mid_rst_y_valid", 32'(bus.y_valid), 32'd0);
    chk("mid_rst_sel",     32'(bus.sel),     32'd0);
    chk("mid_rst_y_data",  32'(bus.y_data),  32'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_a_ready", 32'(bus.a_ready), 32'd1);
    chk("post_rst_b_ready", 32'(bus.b_ready), 32'd0);
    step();
    chk("post_rst_y_valid", 32'(bus.y_valid), 32'd1);
    chk("post_rst_sel",     32'(bus.sel),     32'd0);
    chk("post_rst_y_data",  32'(bus.y_data),  32'hD1);
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
